// File: rtl/manchester_encoder.sv
// rtl/manchester_encoder.sv - byte-stream to IEEE 802.3 Manchester line encoder with end-of-transmission delimiter
module manchester_encoder #(
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_line,
  output logic       tx_active,
  output logic       underrun
);

  localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int EW = $clog2(4 * HALF_BIT_CYCLES);
  localparam logic [CW-1:0] HALF_MAX = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [EW-1:0] ETD_MAX  = EW'(4 * HALF_BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, ETD} state_t;

  state_t        state;
  logic [7:0]    shift_reg;
  logic          cur_last;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          hold_last;
  logic [CW-1:0] half_cnt;
  logic          half_idx;
  logic [2:0]    bit_idx;
  logic [EW-1:0] etd_cnt;

  logic take;
  logic half_end;

  // Holding register is the only buffer the upstream sees; the delimiter phase refuses input.
  assign in_ready = (state != ETD) && !hold_full;
  assign take     = in_valid && in_ready;
  assign half_end = (half_cnt == HALF_MAX);

  // Single FSM: serializes LSB first, first half carries ~bit and second half carries bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cur_last  <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      half_cnt  <= '0;
      half_idx  <= 1'b0;
      bit_idx   <= '0;
      etd_cnt   <= '0;
      tx_line   <= 1'b0;
      tx_active <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            shift_reg <= in_data;
            cur_last  <= in_last;
            half_cnt  <= '0;
            half_idx  <= 1'b0;
            bit_idx   <= '0;
            tx_line   <= ~in_data[0];
            tx_active <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (take) begin
            hold_data <= in_data;
            hold_last <= in_last;
            hold_full <= 1'b1;
          end
          if (!half_end) begin
            half_cnt <= half_cnt + CW'(1);
          end else begin
            half_cnt <= '0;
            if (!half_idx) begin
              half_idx <= 1'b1;
              tx_line  <= shift_reg[0];
            end else begin
              half_idx <= 1'b0;
              if (bit_idx != 3'd7) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {1'b0, shift_reg[7:1]};
                tx_line   <= ~shift_reg[1];
              end else if (cur_last) begin
                // Anything buffered after the last byte is discarded.
                state     <= ETD;
                etd_cnt   <= '0;
                tx_line   <= 1'b1;
                hold_full <= 1'b0;
              end else if (hold_full) begin
                shift_reg <= hold_data;
                cur_last  <= hold_last;
                hold_full <= 1'b0;
                bit_idx   <= '0;
                tx_line   <= ~hold_data[0];
              end else begin
                // Starved mid-frame: close the frame; a byte arriving this very cycle is dropped.
                state     <= ETD;
                etd_cnt   <= '0;
                tx_line   <= 1'b1;
                underrun  <= 1'b1;
                hold_full <= 1'b0;
              end
            end
          end
        end
        ETD: begin
          if (etd_cnt == ETD_MAX) begin
            state     <= IDLE;
            tx_line   <= 1'b0;
            tx_active <= 1'b0;
            hold_full <= 1'b0;
          end else begin
            etd_cnt <= etd_cnt + EW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_encoder.sv
// tb/tb_manchester_encoder.sv - scoreboard bench for manchester_encoder at half-bit counts 1, 2 and 4
module tb_manchester_encoder;

  typedef struct {
    int nbytes;
    bit und;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  int         sel;

  logic v1, v2, v4;
  logic r1, r2, r4;
  logic l1, l2, l4;
  logic a1, a2, a4;
  logic u1_und, u2_und, u4_und;
  logic m_ready, m_line, m_active, m_underrun;

  int n_pass = 0;
  int n_total = 0;

  frame_t     exp_frames[$];
  logic [7:0] exp_bytes[$];
  logic       samples [0:8191];

  bit mon_in_frame = 1'b0;
  int mon_ns = 0;
  int mon_nu = 0;

  always #5 clk = ~clk;

  assign v1 = in_valid && (sel == 1);
  assign v2 = in_valid && (sel == 2);
  assign v4 = in_valid && (sel == 4);

  assign m_ready    = (sel == 1) ? r1 : (sel == 2) ? r2 : r4;
  assign m_line     = (sel == 1) ? l1 : (sel == 2) ? l2 : l4;
  assign m_active   = (sel == 1) ? a1 : (sel == 2) ? a2 : a4;
  assign m_underrun = (sel == 1) ? u1_und : (sel == 2) ? u2_und : u4_und;

  manchester_encoder #(.HALF_BIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1), .in_last(in_last),
    .in_ready(r1), .tx_line(l1), .tx_active(a1), .underrun(u1_und)
  );
  manchester_encoder #(.HALF_BIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v2), .in_last(in_last),
    .in_ready(r2), .tx_line(l2), .tx_active(a2), .underrun(u2_und)
  );
  manchester_encoder #(.HALF_BIT_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v4), .in_last(in_last),
    .in_ready(r4), .tx_line(l4), .tx_active(a4), .underrun(u4_und)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decode a captured frame: halves must be steady and complementary, second half is the bit.
  task automatic check_frame(input int h, input int ns, input int nu);
    frame_t f;
    logic [7:0] b, e;
    bit sym_ok, etd_ok;
    int base;
    if (exp_frames.size() == 0) begin
      check("unexpected_frame", exp_frames.size(), 1);
      return;
    end
    f = exp_frames.pop_front();
    check("active_len", ns, (16 * f.nbytes + 4) * h);
    check("underrun_cnt", nu, f.und ? 1 : 0);
    for (int k = 0; k < f.nbytes; k++) begin
      b = '0;
      sym_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        base = (k * 16 + 2 * i) * h;
        if (base + 2 * h > ns || base + 2 * h > 8192) begin
          sym_ok = 1'b0;
        end else begin
          for (int c = 0; c < h; c++) begin
            if (samples[base + c] !== samples[base]) sym_ok = 1'b0;
            if (samples[base + h + c] !== samples[base + h]) sym_ok = 1'b0;
          end
          if (samples[base] === samples[base + h]) sym_ok = 1'b0;
          b[i] = samples[base + h];
        end
      end
      e = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
      check("byte", b, e);
      check("symbols", sym_ok, 1);
    end
    etd_ok = (ns == (16 * f.nbytes + 4) * h);
    for (int j = 16 * f.nbytes * h; j < ns && j < 8192; j++)
      if (samples[j] !== 1'b1) etd_ok = 1'b0;
    check("etd_high", etd_ok, 1);
  endtask

  // Monitor: capture the line while tx_active is high, score the frame when it drops.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_in_frame = 1'b0;
      end else if (m_active) begin
        if (!mon_in_frame) begin
          mon_in_frame = 1'b1;
          mon_ns = 0;
          mon_nu = 0;
        end
        if (mon_ns < 8192) samples[mon_ns] = m_line;
        mon_ns++;
        if (m_underrun) mon_nu++;
      end else if (mon_in_frame) begin
        mon_in_frame = 1'b0;
        check("idle_line", m_line, 0);
        check_frame(sel, mon_ns, mon_nu);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    while (!m_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("send_ready_timeout", m_ready, 1);
    @(posedge clk);
  endtask

  task automatic drop;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (exp_frames.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("frame_timeout", exp_frames.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    sel = 2;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_line", l2, 0);
    check("rst_tx_active", a2, 0);
    check("rst_underrun", u2_und, 0);
    check("rst_in_ready", r2, 1);
    check("rst_in_ready_h1", r1, 1);
    check("rst_in_ready_h4", r4, 1);

    // Single byte 0xA5, HALF=2
    sel = 2;
    exp_frames.push_back('{nbytes: 1, und: 1'b0});
    exp_bytes.push_back(8'hA5);
    send(8'hA5, 1'b1);
    drop();
    wait_done();

    // Back-to-back 0x00 0xFF 0x3C, HALF=1
    sel = 1;
    exp_frames.push_back('{nbytes: 3, und: 1'b0});
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'h3C);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    #1 check("b2b_ready_low", r1, 0);
    send(8'h3C, 1'b1);
    drop();
    wait_done();

    // Underrun: 0x55 without last, HALF=2
    sel = 2;
    exp_frames.push_back('{nbytes: 1, und: 1'b1});
    exp_bytes.push_back(8'h55);
    send(8'h55, 1'b0);
    drop();
    wait_done();
    check("post_underrun_ready", r2, 1);

    // Mid-frame reset during bit 3, then a clean 0x81 frame
    sel = 2;
    send(8'h12, 1'b0);
    drop();
    repeat (12) @(negedge clk);
    check("pre_reset_active", a2, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_line", l2, 0);
    check("async_rst_active", a2, 0);
    check("async_rst_ready", r2, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_frames.push_back('{nbytes: 1, und: 1'b0});
    exp_bytes.push_back(8'h81);
    send(8'h81, 1'b1);
    drop();
    wait_done();

    // Loopback: 64 random bytes, HALF=4
    sel = 4;
    exp_frames.push_back('{nbytes: 64, und: 1'b0});
    for (int i = 0; i < 64; i++) begin
      rb = 8'($urandom);
      exp_bytes.push_back(rb);
      send(rb, (i == 63));
    end
    drop();
    wait_done();

    check("leftover_bytes", exp_bytes.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
